// File: rtl/demux_ser.sv
// Demultiplexing serialiser: accepts a wide word plus a channel select and
// emits it one SYS_DWIDTH slice per cycle on the selected output channel.
module demux_ser #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int LSB_FIRST  = 1
) (
  input  logic                         clk_sys,
  input  logic                         rst_n,
  input  logic [1:0]                   select,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int NSLICE = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [MST_DWIDTH-1:0]        word_q, word_d;
  logic [1:0]                   sel_q, sel_d;
  logic [NUM_CH*SYS_DWIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0]            valid_q, valid_d;
  logic                         err_q, err_d;

  logic                  last_slice;
  logic                  accept;
  logic                  sel_ok;
  logic                  emit;
  logic [MST_DWIDTH-1:0] slice_word;
  logic [1:0]            slice_ch;
  int                    slice_idx;
  int                    slice_pos;
  logic [SYS_DWIDTH-1:0] slice;

  assign last_slice = (state_q == SEND) && (cnt_q == CW'(NSLICE - 1));
  assign ready_o    = (state_q == IDLE) || last_slice;
  assign accept     = valid_i && ready_o;
  assign sel_ok     = int'(select) < NUM_CH;

  // The slice for the cycle after an accept comes straight from data_i so the
  // first slice appears without a bubble; later slices come from word_q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    sel_d      = sel_q;
    data_d     = data_q;
    valid_d    = '0;
    err_d      = 1'b0;
    emit       = 1'b0;
    slice_word = word_q;
    slice_ch   = sel_q;
    slice_idx  = 0;
    slice_pos  = 0;
    slice      = '0;

    if (accept) begin
      if (sel_ok) begin
        state_d    = SEND;
        cnt_d      = '0;
        word_d     = data_i;
        sel_d      = select;
        emit       = 1'b1;
        slice_word = data_i;
        slice_ch   = select;
        slice_idx  = 0;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end else if (state_q == SEND) begin
      if (last_slice) begin
        state_d = IDLE;
      end else begin
        cnt_d     = cnt_q + CW'(1);
        emit      = 1'b1;
        slice_idx = int'(cnt_q) + 1;
      end
    end

    slice_pos = (LSB_FIRST != 0) ? slice_idx : (NSLICE - 1 - slice_idx);
    for (int s = 0; s < NSLICE; s++) begin
      if (s == slice_pos) slice = slice_word[s*SYS_DWIDTH +: SYS_DWIDTH];
    end

    if (emit) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (ch == int'(slice_ch)) begin
          data_d[ch*SYS_DWIDTH +: SYS_DWIDTH] = slice;
          valid_d[ch]                         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q == SEND);

endmodule

// File: tb/tb_demux_ser.sv
// Directed bench for demux_ser: default LSB-first instance plus an MSB-first
// instance, both on a shared clock and reset.
module tb_demux_ser;

  logic        clk_sys;
  logic        rst_n;

  logic [1:0]  select;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [23:0] data_o;
  logic [2:0]  valid_o;
  logic        busy_o;
  logic        err_o;

  logic [1:0]  m_select;
  logic [31:0] m_data_i;
  logic        m_valid_i;
  logic        m_ready_o;
  logic [23:0] m_data_o;
  logic [2:0]  m_valid_o;
  logic        m_busy_o;
  logic        m_err_o;

  int total;
  int bad;

  demux_ser dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .select  (select),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  demux_ser #(.LSB_FIRST(0)) dut_msb (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .select  (m_select),
    .data_i  (m_data_i),
    .valid_i (m_valid_i),
    .ready_o (m_ready_o),
    .data_o  (m_data_o),
    .valid_o (m_valid_o),
    .busy_o  (m_busy_o),
    .err_o   (m_err_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic test_reset();
    #1;
    total++;
    if ({ready_o, busy_o, err_o, valid_o, data_o} !== {1'b1, 1'b0, 1'b0, 3'b000, 24'h0}) begin
      bad++;
      $display("[TB] FAIL reset_state: got rdy=%b busy=%b err=%b vld=%b data=%h, want rdy=1 busy=0 err=0 vld=000 data=000000",
               ready_o, busy_o, err_o, valid_o, data_o);
    end
    total++;
    if ({m_ready_o, m_busy_o, m_err_o, m_valid_o, m_data_o} !== {1'b1, 1'b0, 1'b0, 3'b000, 24'h0}) begin
      bad++;
      $display("[TB] FAIL reset_state_msb: got rdy=%b busy=%b vld=%b data=%h", m_ready_o, m_busy_o, m_valid_o, m_data_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(posedge clk_sys); #1;
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; select = 2'd1;
    @(posedge clk_sys); #1;
    valid_i = 1'b0; data_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total++;
      if (valid_o !== 3'b010 || data_o[15:8] !== exp_b[i]) begin
        bad++;
        $display("[TB] FAIL single_slice%0d: got vld=%b ch1=%h, want vld=010 ch1=%h", i, valid_o, data_o[15:8], exp_b[i]);
      end
      total++;
      if (ready_o !== (i == 3) || busy_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL single_flags%0d: got rdy=%b busy=%b, want rdy=%b busy=1", i, ready_o, busy_o, (i == 3));
      end
    end
    @(negedge clk_sys);
    total++;
    if (valid_o !== 3'b000 || busy_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 24'h00DD00) begin
      bad++;
      $display("[TB] FAIL single_idle: got vld=%b busy=%b rdy=%b data=%h, want 000 0 1 00DD00", valid_o, busy_o, ready_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_v;
    logic [7:0] got_b;
    @(posedge clk_sys); #1;
    valid_i = 1'b1; data_i = 32'h04030201; select = 2'd0;
    @(posedge clk_sys); #1;
    data_i = 32'h08070605; select = 2'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      exp_v = (i < 4) ? 3'b001 : 3'b100;
      got_b = (i < 4) ? data_o[7:0] : data_o[23:16];
      total++;
      if (valid_o !== exp_v || got_b !== 8'(i + 1)) begin
        bad++;
        $display("[TB] FAIL b2b_slice%0d: got vld=%b byte=%h, want vld=%b byte=%h", i, valid_o, got_b, exp_v, 8'(i + 1));
      end
      if (i == 3) begin
        @(posedge clk_sys); #1;
        valid_i = 1'b0; data_i = 32'h0; select = 2'd0;
      end
    end
    @(negedge clk_sys);
    total++;
    if (valid_o !== 3'b000 || busy_o !== 1'b0 || data_o !== 24'h08DD04) begin
      bad++;
      $display("[TB] FAIL b2b_idle: got vld=%b busy=%b data=%h, want 000 0 08DD04", valid_o, busy_o, data_o);
    end
  endtask

  task automatic test_bad_select();
    @(posedge clk_sys); #1;
    valid_i = 1'b1; data_i = 32'h55667788; select = 2'd3;
    @(posedge clk_sys); #1;
    valid_i = 1'b0; select = 2'd0;
    @(negedge clk_sys);
    total++;
    if (err_o !== 1'b1 || valid_o !== 3'b000 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bad_sel_pulse: got err=%b vld=%b rdy=%b busy=%b, want 1 000 1 0", err_o, valid_o, ready_o, busy_o);
    end
    @(negedge clk_sys);
    total++;
    if (err_o !== 1'b0 || valid_o !== 3'b000 || data_o !== 24'h08DD04) begin
      bad++;
      $display("[TB] FAIL bad_sel_after: got err=%b vld=%b data=%h, want 0 000 08DD04", err_o, valid_o, data_o);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(posedge clk_sys); #1;
    m_valid_i = 1'b1; m_data_i = 32'h11223344; m_select = 2'd0;
    @(posedge clk_sys); #1;
    m_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total++;
      if (m_valid_o !== 3'b001 || m_data_o[7:0] !== exp_b[i]) begin
        bad++;
        $display("[TB] FAIL msb_slice%0d: got vld=%b ch0=%h, want vld=001 ch0=%h", i, m_valid_o, m_data_o[7:0], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [2];
    exp_b = '{8'hAA, 8'hBB};
    @(posedge clk_sys); #1;
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; select = 2'd1;
    @(posedge clk_sys); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_sys);
      total++;
      if (valid_o !== 3'b010 || data_o[15:8] !== exp_b[i]) begin
        bad++;
        $display("[TB] FAIL rstmid_slice%0d: got vld=%b ch1=%h, want 010 %h", i, valid_o, data_o[15:8], exp_b[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({valid_o, data_o, busy_o, err_o, ready_o} !== {3'b000, 24'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL rstmid_abort: got vld=%b data=%h busy=%b err=%b rdy=%b, want 000 000000 0 0 1",
               valid_o, data_o, busy_o, err_o, ready_o);
    end
    @(negedge clk_sys); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      total++;
      if (valid_o !== 3'b000 || busy_o !== 1'b0 || data_o !== 24'h0) begin
        bad++;
        $display("[TB] FAIL rstmid_quiet%0d: got vld=%b busy=%b data=%h, want 000 0 000000", i, valid_o, busy_o, data_o);
      end
    end
  endtask

  task automatic test_select_toggle();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(posedge clk_sys); #1;
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; select = 2'd2;
    @(posedge clk_sys); #1;
    valid_i = 1'b0; select = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total++;
      if (valid_o !== 3'b100 || data_o[23:16] !== exp_b[i]) begin
        bad++;
        $display("[TB] FAIL toggle_slice%0d: got vld=%b ch2=%h, want 100 %h", i, valid_o, data_o[23:16], exp_b[i]);
      end
      select = 2'(i + 1);
    end
    select = 2'd0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    select = 2'd0; data_i = 32'h0; valid_i = 1'b0;
    m_select = 2'd0; m_data_i = 32'h0; m_valid_i = 1'b0;
    #22;
    test_reset();
    @(negedge clk_sys); #1 rst_n = 1'b1;
    test_single();
    test_back_to_back();
    test_bad_select();
    test_msb_first();
    test_reset_mid();
    test_select_toggle();
    repeat (2) @(posedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
